fifo_rd_sequencer: RTL and testbench
====================================

Name: fifo_rd_sequencer

Overview:
- Read-side controller for the async FIFO, clocked in the read (consumer) clock domain.
- Watches the FIFO empty flag, pops one word at a time with a single-cycle read-increment pulse, and presents the word to a serial transmitter using a valid/busy handshake.
- Enforces a programmable inter-frame gap, recovers from an unresponsive consumer through a timeout, and counts delivered words.

Parameters:
- DATA_WIDTH, 8, width of FIFO read data and tx data.
- GAP_CYCLES, 2, minimum idle cycles after consumer busy falls before the next pop; 0 means no gap.
- ACK_TIMEOUT, 16, cycles to wait for consumer busy to rise before abandoning the word.
- CNT_WIDTH, 8, width of the delivered-word counter.

Ports:
- i_clk  input  1  read-domain clock (same clock as the FIFO read side).
- i_rst_n  input  1  asynchronous active-low reset.
- i_enable  input  1  permits new pops; an in-flight transfer always completes.
- i_fifo_empty  input  1  FIFO empty flag, registered in i_clk domain.
- i_fifo_rd_data  input  DATA_WIDTH  FIFO word at the current read address, valid while not empty.
- i_tx_busy  input  1  consumer busy; high while a word is being transmitted.
- o_fifo_r_inc  output  1  one-cycle read-increment pulse to the FIFO.
- o_tx_data  output  DATA_WIDTH  word held for the consumer.
- o_tx_valid  output  1  word available; held until the consumer accepts it.
- o_busy  output  1  high whenever state is not IDLE.
- o_timeout  output  1  one-cycle pulse when a word is abandoned.
- o_sent_cnt  output  CNT_WIDTH  count of words accepted by the consumer; wraps.

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0, gap and timeout counters 0.
- All outputs are registered.
- FSM states: IDLE, WAIT_ACK, WAIT_DONE, GAP.
- IDLE:
  - When i_enable=1 and i_fifo_empty=0, on that edge: capture i_fifo_rd_data into o_tx_data, set o_tx_valid=1, set o_fifo_r_inc=1, go to WAIT_ACK.
  - Latency from the not-empty sample to valid and r_inc is 1 cycle.
- o_fifo_r_inc is high for exactly one cycle per pop. It is never asserted when i_fifo_empty was 1 at the sampling edge.
- WAIT_ACK:
  - The timeout counter increments each cycle.
  - If i_tx_busy=1: clear o_tx_valid, increment o_sent_cnt, go to WAIT_DONE.
  - Else, if the counter reaches ACK_TIMEOUT-1: clear o_tx_valid, pulse o_timeout, go to GAP. The word is dropped and o_sent_cnt is not incremented.
  - busy and timeout in the same cycle: busy wins.
- WAIT_DONE:
  - Wait for i_tx_busy=0.
  - On that edge, load the gap counter and go to GAP. If GAP_CYCLES=0, go directly to IDLE.
- GAP:
  - Count GAP_CYCLES cycles, then go to IDLE.
  - No pop is possible during GAP.
- The stale-empty hazard is excluded by construction. At least 2 cycles separate consecutive pops, so the FIFO's registered empty flag has updated before IDLE samples it again.
- i_enable falling:
  - Has no effect on a transfer in WAIT_ACK, WAIT_DONE or GAP.
  - Blocks only the next pop from IDLE.
- o_tx_data holds its last value after valid drops. It changes only on a pop.
- o_sent_cnt wraps modulo 2^CNT_WIDTH with no saturation.
- i_fifo_empty rising while in WAIT_ACK or WAIT_DONE is ignored.
- Reset asserted mid-transfer: state returns to IDLE immediately, o_tx_valid and o_fifo_r_inc clear asynchronously, and no further pop occurs until after release.

Test Plan:
- Single word: FIFO holds 0xA5, enable=1, consumer raises busy 2 cycles after valid and drops it 10 cycles later -> r_inc pulses exactly once, o_tx_data=0xA5, valid high until busy, o_sent_cnt=1, next pop no earlier than GAP_CYCLES=2 cycles after busy falls.
- Burst of 4 words (0x01..0x04) with a well-behaved consumer -> exactly 4 r_inc pulses, data delivered in order, o_sent_cnt=4, no r_inc once empty=1, o_busy=0 at the end.
- Timeout: a word is pending and busy is held at 0 -> o_timeout pulses at valid+ACK_TIMEOUT (16) cycles, valid drops, o_sent_cnt unchanged, next word popped after the gap.
- Enable gating: empty=0 with i_enable=0 -> no r_inc for 50 cycles. Drop i_enable mid-WAIT_DONE -> the current word completes and no new pop follows.
- Counter wrap: deliver 256 words with CNT_WIDTH=8 -> o_sent_cnt returns to 0.
- Async reset during WAIT_ACK -> o_tx_valid=0, o_busy=0, o_sent_cnt=0 immediately. After release with FIFO not empty, a pop occurs 1 cycle after the first sampling edge.

Source files
------------

// File: rtl/fifo_rd_sequencer.sv
// Read-side sequencer for the async FIFO, running in the consumer clock domain.
// Pops one word at a time when the FIFO is not empty and presents it to a serial
// transmitter over a valid/busy handshake. It enforces an inter-frame gap, drops
// the word if the consumer never answers, and counts accepted words.
//
// Ports:
//   i_clk, i_rst_n   read-domain clock, async active-low reset
//   i_enable         permits new pops from IDLE; in-flight transfers always finish
//   i_fifo_empty     registered FIFO empty flag
//   i_fifo_rd_data   FIFO word at the current read address
//   i_tx_busy        consumer busy (high while transmitting)
//   o_fifo_r_inc     one-cycle read-increment pulse per pop
//   o_tx_data        word held for the consumer; changes only on a pop
//   o_tx_valid       word pending, held until accepted or abandoned
//   o_busy           state is not IDLE
//   o_timeout        one-cycle pulse when a pending word is abandoned
//   o_sent_cnt       wrapping count of words accepted by the consumer
module fifo_rd_sequencer #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned GAP_CYCLES  = 2,
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter int unsigned CNT_WIDTH   = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_enable,
    input  logic                  i_fifo_empty,
    input  logic [DATA_WIDTH-1:0] i_fifo_rd_data,
    input  logic                  i_tx_busy,
    output logic                  o_fifo_r_inc,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_valid,
    output logic                  o_busy,
    output logic                  o_timeout,
    output logic [CNT_WIDTH-1:0]  o_sent_cnt
);

    localparam int unsigned TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
    // Gap counter counts down to zero, so it is loaded with one less than the gap.
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam bit               HAS_GAP  = (GAP_CYCLES > 0);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_t;

    state_t                  state, state_d;
    logic [TMO_W-1:0]        tmo_cnt, tmo_cnt_d;
    logic [GAP_W-1:0]        gap_cnt, gap_cnt_d;
    logic                    r_inc_d, valid_d, timeout_d;
    logic [DATA_WIDTH-1:0]   data_d;
    logic [CNT_WIDTH-1:0]    sent_cnt_d;
    logic                    pop_c;
    logic                    tmo_hit_c;

    assign pop_c     = (state == IDLE) && i_enable && !i_fifo_empty;
    assign tmo_hit_c = (tmo_cnt == TMO_LAST);

    // State and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            tmo_cnt      <= '0;
            gap_cnt      <= '0;
            o_fifo_r_inc <= 1'b0;
            o_tx_data    <= '0;
            o_tx_valid   <= 1'b0;
            o_busy       <= 1'b0;
            o_timeout    <= 1'b0;
            o_sent_cnt   <= '0;
        end else begin
            state        <= state_d;
            tmo_cnt      <= tmo_cnt_d;
            gap_cnt      <= gap_cnt_d;
            o_fifo_r_inc <= r_inc_d;
            o_tx_data    <= data_d;
            o_tx_valid   <= valid_d;
            o_busy       <= (state_d != IDLE);
            o_timeout    <= timeout_d;
            o_sent_cnt   <= sent_cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (pop_c) state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                // Consumer acceptance takes priority over a simultaneous timeout.
                if (i_tx_busy)      state_d = WAIT_DONE;
                else if (tmo_hit_c) state_d = HAS_GAP ? GAP : IDLE;
            end
            WAIT_DONE: begin
                if (!i_tx_busy) state_d = HAS_GAP ? GAP : IDLE;
            end
            GAP: begin
                if (gap_cnt == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and internal counters.
    always_comb begin
        r_inc_d    = 1'b0;
        timeout_d  = 1'b0;
        valid_d    = o_tx_valid;
        data_d     = o_tx_data;
        sent_cnt_d = o_sent_cnt;
        tmo_cnt_d  = tmo_cnt;
        gap_cnt_d  = gap_cnt;
        unique case (state)
            IDLE: begin
                if (pop_c) begin
                    data_d    = i_fifo_rd_data;
                    valid_d   = 1'b1;
                    r_inc_d   = 1'b1;
                    tmo_cnt_d = '0;
                end
            end
            WAIT_ACK: begin
                tmo_cnt_d = tmo_cnt + TMO_W'(1);
                if (i_tx_busy) begin
                    valid_d    = 1'b0;
                    sent_cnt_d = o_sent_cnt + CNT_WIDTH'(1);
                end else if (tmo_hit_c) begin
                    valid_d   = 1'b0;
                    timeout_d = 1'b1;
                    gap_cnt_d = GAP_LOAD;
                end
            end
            WAIT_DONE: begin
                if (!i_tx_busy) gap_cnt_d = GAP_LOAD;
            end
            GAP: begin
                if (gap_cnt != '0) gap_cnt_d = gap_cnt - GAP_W'(1);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fifo_rd_sequencer.sv
// Directed bench for fifo_rd_sequencer with default parameters
// (DATA_WIDTH=8, GAP_CYCLES=2, ACK_TIMEOUT=16, CNT_WIDTH=8).
// A queue stands in for the FIFO; the consumer handshake is driven inline.
module tb_fifo_rd_sequencer;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_enable;
    logic       i_fifo_empty;
    logic [7:0] i_fifo_rd_data;
    logic       i_tx_busy;
    logic       o_fifo_r_inc;
    logic [7:0] o_tx_data;
    logic       o_tx_valid;
    logic       o_busy;
    logic       o_timeout;
    logic [7:0] o_sent_cnt;

    int n_total = 0;
    int n_bad   = 0;
    int n_pops  = 0;
    logic [7:0] q[$];

    fifo_rd_sequencer dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_enable       (i_enable),
        .i_fifo_empty   (i_fifo_empty),
        .i_fifo_rd_data (i_fifo_rd_data),
        .i_tx_busy      (i_tx_busy),
        .o_fifo_r_inc   (o_fifo_r_inc),
        .o_tx_data      (o_tx_data),
        .o_tx_valid     (o_tx_valid),
        .o_busy         (o_busy),
        .o_timeout      (o_timeout),
        .o_sent_cnt     (o_sent_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic fifo_upd();
        i_fifo_empty   = (q.size() == 0);
        i_fifo_rd_data = (q.size() == 0) ? 8'h00 : q[0];
    endtask

    task automatic push(input logic [7:0] d);
        q.push_back(d);
        fifo_upd();
    endtask

    // One clock; sample 1 ns after the edge and retire a popped word from the model.
    task automatic tick();
        @(posedge i_clk);
        #1;
        if (o_fifo_r_inc === 1'b1) begin
            n_pops++;
            if (q.size() > 0) q.delete(0);
        end
        fifo_upd();
    endtask

    task automatic wait_pop(input int max, output int n);
        n = 0;
        while (n < max) begin
            tick();
            n++;
            if (o_fifo_r_inc === 1'b1) return;
        end
        check("pop_wait_expired", 32'(0), 32'(1));
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (o_busy !== 1'b0 && n < max) begin
            tick();
            n++;
        end
        check("idle_wait", 32'(o_busy), 32'(0));
    endtask

    // Consumer: raise busy after 'delay' cycles, keep it high for 'hold' cycles.
    task automatic serve(input int delay, input int hold);
        for (int k = 0; k < delay; k++) tick();
        check("valid_before_ack", 32'(o_tx_valid), 32'(1));
        i_tx_busy = 1'b1;
        tick();
        check("valid_after_ack", 32'(o_tx_valid), 32'(0));
        check("busy_in_done", 32'(o_busy), 32'(1));
        for (int k = 1; k < hold; k++) tick();
        i_tx_busy = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int p0;
        logic [7:0] c0;

        i_rst_n   = 1'b1;
        i_enable  = 1'b0;
        i_tx_busy = 1'b0;
        fifo_upd();
        #1 i_rst_n = 1'b0;
        #2;
        check("rst_r_inc", 32'(o_fifo_r_inc), 32'(0));
        check("rst_valid", 32'(o_tx_valid), 32'(0));
        check("rst_busy", 32'(o_busy), 32'(0));
        check("rst_timeout", 32'(o_timeout), 32'(0));
        check("rst_cnt", 32'(o_sent_cnt), 32'(0));
        check("rst_data", 32'(o_tx_data), 32'(0));
        tick();
        tick();
        i_rst_n  = 1'b1;
        i_enable = 1'b1;
        tick();
        check("empty_no_pop", 32'(n_pops), 32'(0));

        // Single word with a two-cycle ack delay and a ten-cycle busy window.
        push(8'hA5);
        wait_pop(5, n);
        check("single_lat", 32'(n), 32'(1));
        check("single_rinc", 32'(o_fifo_r_inc), 32'(1));
        check("single_valid", 32'(o_tx_valid), 32'(1));
        check("single_data", 32'(o_tx_data), 32'(8'hA5));
        check("single_busy", 32'(o_busy), 32'(1));
        push(8'h5A);
        tick();
        check("rinc_one_cycle", 32'(o_fifo_r_inc), 32'(0));
        check("valid_held", 32'(o_tx_valid), 32'(1));
        serve(1, 10);
        check("single_cnt", 32'(o_sent_cnt), 32'(1));
        check("single_pops", 32'(n_pops), 32'(1));
        check("data_held", 32'(o_tx_data), 32'(8'hA5));
        // busy low sampled, two GAP cycles, IDLE, then the pop edge
        wait_pop(10, n);
        check("gap_pop_dist", 32'(n), 32'(4));
        check("second_data", 32'(o_tx_data), 32'(8'h5A));
        serve(0, 1);
        wait_idle(20);
        check("second_cnt", 32'(o_sent_cnt), 32'(2));

        // Burst of four words.
        p0 = n_pops;
        c0 = o_sent_cnt;
        for (int k = 1; k <= 4; k++) push(8'(k));
        for (int k = 1; k <= 4; k++) begin
            wait_pop(20, n);
            check("burst_data", 32'(o_tx_data), 32'(k));
            serve(1, 3);
        end
        wait_idle(20);
        check("burst_pops", 32'(n_pops - p0), 32'(4));
        check("burst_cnt", 32'(o_sent_cnt), 32'(8'(c0 + 8'd4)));
        repeat (10) tick();
        check("burst_no_extra", 32'(n_pops - p0), 32'(4));
        check("burst_idle", 32'(o_busy), 32'(0));

        // Timeout: consumer never answers.
        push(8'h77);
        push(8'h88);
        wait_pop(5, n);
        check("tmo_data", 32'(o_tx_data), 32'(8'h77));
        for (int k = 1; k <= 15; k++) tick();
        check("tmo_early", 32'(o_timeout), 32'(0));
        check("tmo_valid_early", 32'(o_tx_valid), 32'(1));
        tick();
        check("tmo_pulse", 32'(o_timeout), 32'(1));
        check("tmo_valid_drop", 32'(o_tx_valid), 32'(0));
        check("tmo_cnt_same", 32'(o_sent_cnt), 32'(6));
        check("tmo_in_gap", 32'(o_busy), 32'(1));
        tick();
        check("tmo_one_cycle", 32'(o_timeout), 32'(0));
        wait_pop(10, n);
        check("tmo_next_pop", 32'(n), 32'(2));
        check("tmo_next_data", 32'(o_tx_data), 32'(8'h88));
        serve(0, 1);
        wait_idle(20);
        check("tmo_after_cnt", 32'(o_sent_cnt), 32'(7));

        // Enable gating.
        i_enable = 1'b0;
        push(8'h99);
        p0 = n_pops;
        repeat (50) tick();
        check("en_gate_pops", 32'(n_pops - p0), 32'(0));
        check("en_gate_busy", 32'(o_busy), 32'(0));
        i_enable = 1'b1;
        wait_pop(5, n);
        check("en_pop_lat", 32'(n), 32'(1));
        check("en_data", 32'(o_tx_data), 32'(8'h99));
        push(8'hAA);
        p0 = n_pops;
        i_tx_busy = 1'b1;
        tick();
        i_enable = 1'b0;
        repeat (3) tick();
        i_tx_busy = 1'b0;
        repeat (20) tick();
        check("en_drop_pops", 32'(n_pops - p0), 32'(0));
        check("en_drop_cnt", 32'(o_sent_cnt), 32'(8));
        check("en_drop_idle", 32'(o_busy), 32'(0));

        // Async reset while a word waits for acknowledgement.
        i_enable = 1'b1;
        wait_pop(5, n);
        check("rst2_data", 32'(o_tx_data), 32'(8'hAA));
        push(8'h3C);
        tick();
        tick();
        check("rst2_pre_valid", 32'(o_tx_valid), 32'(1));
        check("rst2_pre_busy", 32'(o_busy), 32'(1));
        #2 i_rst_n = 1'b0;
        #1;
        check("rst2_valid", 32'(o_tx_valid), 32'(0));
        check("rst2_busy", 32'(o_busy), 32'(0));
        check("rst2_cnt", 32'(o_sent_cnt), 32'(0));
        check("rst2_rinc", 32'(o_fifo_r_inc), 32'(0));
        p0 = n_pops;
        tick();
        tick();
        check("rst2_no_pop", 32'(n_pops - p0), 32'(0));
        #2 i_rst_n = 1'b1;
        tick();
        check("rst2_release_pop", 32'(o_fifo_r_inc), 32'(1));
        check("rst2_release_data", 32'(o_tx_data), 32'(8'h3C));
        serve(0, 1);
        wait_idle(20);
        check("rst2_cnt_one", 32'(o_sent_cnt), 32'(1));

        // Counter wrap: 255 more words make 256 since reset.
        for (int k = 0; k < 255; k++) push(8'(k));
        for (int k = 0; k < 255; k++) begin
            wait_pop(20, n);
            check("wrap_data", 32'(o_tx_data), 32'(k));
            serve(0, 1);
        end
        wait_idle(20);
        check("wrap_cnt", 32'(o_sent_cnt), 32'(0));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
